dbus_req_ctrl: RTL and testbench

- Data-memory request controller for the memory (M) stage of the 5-stage pipeline.
- Turns the M-stage load/store into a valid/addr_ok/data_ok bus transaction and raises d_wait to the hazard unit while the access is outstanding.
- The hazard unit's d_wait branch stalls M and freezes fetch off this signal.
- Also does byte-lane steering for stores and sign/zero extension for loads.

---
 rtl/dbus_req_ctrl_if.sv | 27 ++
 rtl/dbus_req_ctrl.sv | 154 +++++++++++++++
 tb/tb_dbus_req_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_req_ctrl_if.sv
// Data bus request/response bundle between the M-stage controller and memory.
// master: drives dreq_*, receives dresp_*; slave: the memory side.
interface dbus_req_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              dreq_valid;
  logic              dreq_write;
  logic [ADDR_W-1:0] dreq_addr;
  logic [1:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [63:0]       dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [63:0]       dresp_data;

  modport master (
    output dreq_valid, dreq_write, dreq_addr,
    output dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_write, dreq_addr,
    input  dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/dbus_req_ctrl.sv
// M-stage data request controller: issues valid/addr_ok/data_ok bus accesses,
// stalls M via d_wait, steers store lanes and extends load results.
// Ports: clk, resetn; m_* M-stage access; bus (dreq_*/dresp_*);
// d_wait to hazard unit; m_done pulse with m_rdata.
module dbus_req_ctrl #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_valid,
  input  logic              m_write,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [1:0]        m_size,
  input  logic              m_sext,
  input  logic [63:0]       m_wdata,
  dbus_req_ctrl_if.master   bus,
  output logic              d_wait,
  output logic              m_done,
  output logic [63:0]       m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_write;
  logic              r_sext;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [7:0]        r_strobe;
  logic [63:0]       r_data;
  logic [63:0]       r_resp;

  logic        w_issue;
  logic [2:0]  w_off;
  logic [7:0]  w_mask;
  logic [7:0]  w_strobe;
  logic [63:0] w_sdata;
  logic [63:0] w_sh;
  logic [63:0] w_ext;

  // resetn gates the combinational issue path so reset forces all outputs low
  assign w_issue = (r_state == S_IDLE) & m_valid & resetn;
  assign w_off   = m_addr[2:0];

  always_comb begin
    w_mask = 8'hFF;
    case (m_size)
      2'd0:    w_mask = 8'h01;
      2'd1:    w_mask = 8'h03;
      2'd2:    w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign w_strobe = m_write ? (w_mask << w_off) : 8'h00;
  assign w_sdata  = m_wdata << {w_off, 3'b000};

  always_comb begin
    bus.dreq_valid  = 1'b0;
    bus.dreq_write  = 1'b0;
    bus.dreq_addr   = '0;
    bus.dreq_size   = 2'd0;
    bus.dreq_strobe = 8'h00;
    bus.dreq_data   = 64'd0;
    if (w_issue) begin
      bus.dreq_valid  = 1'b1;
      bus.dreq_write  = m_write;
      bus.dreq_addr   = m_addr;
      bus.dreq_size   = m_size;
      bus.dreq_strobe = w_strobe;
      bus.dreq_data   = w_sdata;
    end else if (r_state != S_IDLE) begin
      bus.dreq_valid  = (r_state == S_ADDR);
      bus.dreq_write  = r_write;
      bus.dreq_addr   = r_addr;
      bus.dreq_size   = r_size;
      bus.dreq_strobe = r_strobe;
      bus.dreq_data   = r_data;
    end
  end

  assign d_wait = w_issue | (r_state == S_ADDR) | (r_state == S_DATA);
  assign m_done = (r_state == S_DONE);

  assign w_sh = r_resp >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_ext = w_sh;
    case (r_size)
      2'd0: w_ext = {{56{r_sext & w_sh[7]}}, w_sh[7:0]};
      2'd1: w_ext = {{48{r_sext & w_sh[15]}}, w_sh[15:0]};
      2'd2: w_ext = {{32{r_sext & w_sh[31]}}, w_sh[31:0]};
      default: w_ext = w_sh;
    endcase
  end

  assign m_rdata = (m_done && !r_write) ? w_ext : 64'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_sext   <= 1'b0;
      r_addr   <= '0;
      r_size   <= 2'd0;
      r_strobe <= 8'h00;
      r_data   <= 64'd0;
      r_resp   <= 64'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (m_valid) begin
            r_write  <= m_write;
            r_sext   <= m_sext;
            r_addr   <= m_addr;
            r_size   <= m_size;
            r_strobe <= w_strobe;
            r_data   <= w_sdata;
            if (bus.dresp_addr_ok && bus.dresp_data_ok) begin
              r_resp  <= bus.dresp_data;
              r_state <= S_DONE;
            end else if (bus.dresp_addr_ok) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (bus.dresp_addr_ok && bus.dresp_data_ok) begin
            r_resp  <= bus.dresp_data;
            r_state <= S_DONE;
          end else if (bus.dresp_addr_ok) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.dresp_data_ok) begin
            r_resp  <= bus.dresp_data;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Bench for dbus_req_ctrl: vector table, random accesses against a
// byte-level reference model, and reset corner sequences.
module tb_dbus_req_ctrl;

  logic        clk;
  logic        resetn;
  logic        m_valid;
  logic        m_write;
  logic [63:0] m_addr;
  logic [1:0]  m_size;
  logic        m_sext;
  logic [63:0] m_wdata;
  logic        d_wait;
  logic        m_done;
  logic [63:0] m_rdata;

  int total = 0;
  int bad   = 0;

  dbus_req_ctrl_if #(.ADDR_W(64)) bus ();

  dbus_req_ctrl #(.ADDR_W(64)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .m_valid (m_valid),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_size  (m_size),
    .m_sext  (m_sext),
    .m_wdata (m_wdata),
    .bus     (bus),
    .d_wait  (d_wait),
    .m_done  (m_done),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [1:0]  size;
    bit          sext;
    logic [63:0] wdata;
    logic [63:0] rd;
    int          a;
    int          d;
    logic [63:0] xdata;
    logic [7:0]  xstrb;
    logic [63:0] xrdata;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // reference model: byte-by-byte view of the access
  function automatic logic [7:0] mstrb(logic [63:0] addr,
                                       logic [1:0] size, bit wr);
    int off = int'(addr[2:0]);
    int n   = 1 << size;
    logic [7:0] s = 8'h00;
    if (wr)
      for (int b = 0; b < 8; b++)
        if (b >= off && b < off + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] mstore(logic [63:0] addr,
                                         logic [63:0] wd);
    int off = int'(addr[2:0]);
    logic [63:0] o = 64'd0;
    for (int b = 0; b < 8; b++)
      if (b >= off) o[8*b +: 8] = wd[8*(b-off) +: 8];
    return o;
  endfunction

  function automatic logic [63:0] mload(logic [63:0] addr, logic [1:0] size,
                                        bit sext, logic [63:0] rd);
    int off = int'(addr[2:0]);
    int n   = 1 << size;
    logic [63:0] v = 64'd0;
    logic [7:0]  b;
    bit sg = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = (off + i < 8) ? rd[8*(off+i) +: 8] : 8'h00;
      v[8*i +: 8] = b;
      if (i == n - 1) sg = b[7];
    end
    if (sext && sg)
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_valid = 1'b0;
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      #1;
      chk({tag, ".valid"}, 64'(bus.dreq_valid), 64'd0);
      chk({tag, ".dwait"}, 64'(d_wait), 64'd0);
      chk({tag, ".done"}, 64'(m_done), 64'd0);
    end
  endtask

  // a = cycles before addr_ok; d = cycles from addr_ok to data_ok
  task automatic run(input vec_t v, input string tag);
    bit acc_f = 1'b0;
    bit done  = 1'b0;
    bit aok, dok, want;
    int acc_c = 0;
    int waits = 0;
    @(negedge clk);
    m_valid = 1'b1;
    m_write = v.wr;
    m_addr  = v.addr;
    m_size  = v.size;
    m_sext  = v.sext;
    m_wdata = v.wdata;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!acc_f) begin
        aok  = (cyc == v.a);
        want = aok && (v.d == 0);
        dok  = aok ? want : 1'($urandom_range(0, 1));
      end else begin
        aok  = 1'($urandom_range(0, 1));
        want = (cyc - acc_c == v.d);
        dok  = want ? 1'b1 :
               (cyc - acc_c > v.d) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      bus.dresp_addr_ok = aok;
      bus.dresp_data_ok = dok;
      bus.dresp_data    = want ? v.rd : {$urandom, $urandom};
      #1;
      if (m_done === 1'b1) begin
        done = 1'b1;
        chk({tag, ".waits"}, 64'(waits), 64'(v.a + v.d + 1));
        chk({tag, ".rdata"}, m_rdata, v.xrdata);
        chk({tag, ".dwait0"}, 64'(d_wait), 64'd0);
        chk({tag, ".valid0"}, 64'(bus.dreq_valid), 64'd0);
      end else begin
        waits++;
        chk({tag, ".dwait"}, 64'(d_wait), 64'd1);
        chk({tag, ".valid"}, 64'(bus.dreq_valid), 64'(!acc_f));
        if (!acc_f) begin
          chk({tag, ".addr"}, bus.dreq_addr, v.addr);
          chk({tag, ".wr"}, 64'(bus.dreq_write), 64'(v.wr));
          chk({tag, ".size"}, 64'(bus.dreq_size), 64'(v.size));
          chk({tag, ".strb"}, 64'(bus.dreq_strobe), 64'(v.xstrb));
          if (v.wr) chk({tag, ".wdata"}, bus.dreq_data, v.xdata);
        end
      end
      if (!acc_f && aok) begin
        acc_f = 1'b1;
        acc_c = cyc;
      end
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL %s.timeout: got no m_done want m_done", tag);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 64'(bus.dreq_valid), 64'd0);
    chk({tag, ".dwait"}, 64'(d_wait), 64'd0);
    chk({tag, ".done"}, 64'(m_done), 64'd0);
    chk({tag, ".rdata"}, m_rdata, 64'd0);
    chk({tag, ".addr"}, bus.dreq_addr, 64'd0);
    chk({tag, ".strb"}, 64'(bus.dreq_strobe), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    int n;
    logic [63:0] msk;

    // wr addr size sext wdata rd a d xdata xstrb xrdata
    tbl[0] = '{1'b0, 64'h1003, 2'd0, 1'b1, 64'h0,
               64'h0000_0000_8000_0000, 0, 0,
               64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80};
    tbl[1] = '{1'b1, 64'h2006, 2'd1, 1'b0, 64'h1234,
               64'h0, 3, 1,
               64'h1234_0000_0000_0000, 8'hC0, 64'h0};
    tbl[2] = '{1'b0, 64'h3004, 2'd2, 1'b0, 64'h0,
               64'hFFFF_FFFF_0000_0000, 0, 2,
               64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF};
    tbl[3] = '{1'b0, 64'h12, 2'd1, 1'b1, 64'h0,
               64'h0000_0000_8765_0000, 1, 0,
               64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8765};
    tbl[4] = '{1'b0, 64'h40, 2'd3, 1'b1, 64'h0,
               64'hDEAD_BEEF_0123_4567, 2, 3,
               64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567};
    tbl[5] = '{1'b1, 64'h104, 2'd2, 1'b0, 64'hCAFE_BABE,
               64'h0, 0, 0,
               64'hCAFE_BABE_0000_0000, 8'hF0, 64'h0};
    tbl[6] = '{1'b1, 64'h7, 2'd0, 1'b1, 64'hAB,
               64'h0, 1, 1,
               64'hAB00_0000_0000_0000, 8'h80, 64'h0};
    tbl[7] = '{1'b0, 64'h8, 2'd2, 1'b1, 64'h0,
               64'h0000_0000_8000_0001, 0, 0,
               64'h0, 8'h00, 64'hFFFF_FFFF_8000_0001};
    tbl[8] = '{1'b1, 64'h0, 2'd3, 1'b0, 64'h1122_3344_5566_7788,
               64'h0, 0, 1,
               64'h1122_3344_5566_7788, 8'hFF, 64'h0};

    // reset with a pending M request must keep every output low
    resetn = 1'b0;
    m_valid = 1'b1;
    m_write = 1'b1;
    m_addr = 64'h18;
    m_size = 2'd3;
    m_sext = 1'b0;
    m_wdata = 64'h55;
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 64'h1;
    @(negedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    m_valid = 1'b0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    idle(1, "post_rst");

    // table entries are issued back to back with no idle gap
    for (int i = 0; i < 9; i++)
      run(tbl[i], $sformatf("tbl%0d", i));
    idle(2, "b2b_tail");

    // explicit back-to-back pair
    run(tbl[7], "b2b_a");
    run(tbl[0], "b2b_b");
    idle(1, "b2b_nodup");

    // randomized accesses against the byte model
    for (int k = 0; k < 40; k++) begin
      r.wr    = 1'($urandom_range(0, 1));
      r.size  = 2'($urandom_range(0, 3));
      r.sext  = 1'($urandom_range(0, 1));
      r.wdata = {$urandom, $urandom};
      r.rd    = {$urandom, $urandom};
      r.addr  = {$urandom, $urandom};
      n = 1 << r.size;
      msk = 64'(n - 1);
      if ($urandom_range(0, 7) != 0) r.addr = r.addr & ~msk;
      r.a = int'($urandom_range(0, 3));
      r.d = int'($urandom_range(0, 3));
      r.xstrb  = mstrb(r.addr, r.size, r.wr);
      r.xdata  = mstore(r.addr, r.wdata);
      r.xrdata = r.wr ? 64'd0 : mload(r.addr, r.size, r.sext, r.rd);
      run(r, $sformatf("rnd%0d", k));
      if ($urandom_range(0, 2) == 0) idle(1, "rnd_gap");
    end
    idle(1, "rnd_tail");

    // reset while waiting in the address phase
    @(negedge clk);
    m_valid = 1'b1;
    m_write = 1'b0;
    m_addr = 64'h5000;
    m_size = 2'd2;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    #1;
    chk("raddr.issue", 64'(bus.dreq_valid), 64'd1);
    @(negedge clk);
    #1;
    chk("raddr.hold", 64'(bus.dreq_valid), 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk_zero("raddr.async");
    @(negedge clk);
    m_valid = 1'b0;
    resetn = 1'b1;
    idle(1, "raddr.after");

    // reset while waiting for data, then a stray data_ok
    @(negedge clk);
    m_valid = 1'b1;
    m_write = 1'b0;
    m_addr = 64'h6000;
    m_size = 2'd3;
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b0;
    @(negedge clk);
    bus.dresp_addr_ok = 1'b0;
    #1;
    chk("rdata.dwait", 64'(d_wait), 64'd1);
    chk("rdata.valid", 64'(bus.dreq_valid), 64'd0);
    #1;
    resetn = 1'b0;
    #1;
    chk_zero("rdata.async");
    @(negedge clk);
    m_valid = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data = {$urandom, $urandom};
      #1;
      chk("stray.done", 64'(m_done), 64'd0);
      chk("stray.dwait", 64'(d_wait), 64'd0);
      chk("stray.valid", 64'(bus.dreq_valid), 64'd0);
    end
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;

    // reset during the done cycle clears m_rdata at once
    @(negedge clk);
    m_valid = 1'b1;
    m_write = 1'b0;
    m_addr = 64'h1003;
    m_size = 2'd0;
    m_sext = 1'b1;
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 64'h0000_0000_8000_0000;
    @(negedge clk);
    m_valid = 1'b0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    #1;
    chk("rdone.done", 64'(m_done), 64'd1);
    chk("rdone.rdata", m_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    #1;
    resetn = 1'b0;
    #1;
    chk_zero("rdone.async");
    @(negedge clk);
    resetn = 1'b1;
    idle(1, "end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
